// File: rtl/sev_seg_pkg.sv
// Shared types and the hex-to-segment glyph table for the seven-segment display blocks.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package sev_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] hex);
        seg_t seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sev_seg_scanner_if.sv
// Display bundle: per-digit controls from the result registers and the active-low board pins.
// master = side that owns the digit data; slave = the scanner.
interface sev_seg_scanner_if
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int PWM_BITS = 4
);

    logic [N_DIGITS*4-1:0] digits;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   blank;
    logic [N_DIGITS-1:0]   blink;
    logic [PWM_BITS-1:0]   brightness;

    seg_t                  Seg;
    logic                  DP;
    logic [N_DIGITS-1:0]   AN;
    logic                  frame_tick;

    modport master (
        output digits, dp, blank, blink, brightness,
        input  Seg, DP, AN, frame_tick
    );

    modport slave (
        input  digits, dp, blank, blink, brightness,
        output Seg, DP, AN, frame_tick
    );

endinterface

// File: rtl/sev_seg_hex_decode.sv
// Combinational hex-to-glyph decoder; a thin wrapper so other tops can share the table.
module sev_seg_hex_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg_t       seg_o
);

    assign seg_o = hex_to_seg(hex_i);

endmodule

// File: rtl/sev_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner with per-digit blank/blink/dp, PWM dimming,
// a one-cycle anti-ghosting guard per slot and frame-coherent capture of the inputs.
module sev_seg_scanner
    import sev_seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 100_000,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 256
) (
    input  logic              clk,
    input  logic              resetn,
    sev_seg_scanner_if.slave  disp
);

    localparam int PRE_W  = ($clog2(REFRESH_DIV)  < 1) ? 1 : $clog2(REFRESH_DIV);
    localparam int SLOT_W = ($clog2(N_DIGITS)     < 1) ? 1 : $clog2(N_DIGITS);
    localparam int FRM_W  = ($clog2(BLINK_FRAMES) < 1) ? 1 : $clog2(BLINK_FRAMES);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(N_DIGITS - 1);
    localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_q, phase_d;

    logic [N_DIGITS*4-1:0] digits_sh_q, digits_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [N_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [PWM_BITS-1:0]   bri_sh_q, bri_sh_d;

    logic [N_DIGITS-1:0]   an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  tick_q, tick_d;

    logic                  pre_wrap;
    logic                  slot_wrap;
    logic                  capture;
    logic                  lit;
    logic [3:0]            cur_hex;
    seg_t                  cur_seg;

    assign cur_hex = digits_sh_q[slot_q*4 +: 4];

    sev_seg_hex_decode u_hex_decode (
        .hex_i (cur_hex),
        .seg_o (cur_seg)
    );

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned and infers a latch.
        pre_wrap  = (pre_q == PRE_LAST);
        slot_wrap = pre_wrap && (slot_q == SLOT_LAST);
        capture   = (pre_q == '0) && (slot_q == '0);

        pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
        slot_d  = slot_q;
        pwm_d   = pwm_q + 1'b1;
        frm_d   = frm_q;
        phase_d = phase_q;

        if (pre_wrap) begin
            slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        end

        if (slot_wrap) begin
            if (frm_q == FRM_LAST) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end

        digits_sh_d = digits_sh_q;
        dp_sh_d     = dp_sh_q;
        blank_sh_d  = blank_sh_q;
        blink_sh_d  = blink_sh_q;
        bri_sh_d    = bri_sh_q;
        if (capture) begin
            digits_sh_d = disp.digits;
            dp_sh_d     = disp.dp;
            blank_sh_d  = disp.blank;
            blink_sh_d  = disp.blink;
            bri_sh_d    = disp.brightness;
        end

        // Prescaler value 0 is the guard cycle: anodes stay off while the segment bus settles.
        lit = (pre_q != '0)
            && (pwm_q <= bri_sh_q)
            && !blank_sh_q[slot_q]
            && !(blink_sh_q[slot_q] && phase_q);

        an_d   = lit ? ~(AN_ONE << slot_q) : '1;
        seg_d  = cur_seg;
        dp_d   = ~dp_sh_q[slot_q];
        tick_d = slot_wrap;
    end

    // NOTE: shadow registers are reset along with the counters so a fresh scan never shows stale digits.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pre_q       <= '0;
            slot_q      <= '0;
            pwm_q       <= '0;
            frm_q       <= '0;
            phase_q     <= 1'b0;
            digits_sh_q <= '0;
            dp_sh_q     <= '0;
            blank_sh_q  <= '0;
            blink_sh_q  <= '0;
            bri_sh_q    <= '0;
            an_q        <= '1;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            tick_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            slot_q      <= slot_d;
            pwm_q       <= pwm_d;
            frm_q       <= frm_d;
            phase_q     <= phase_d;
            digits_sh_q <= digits_sh_d;
            dp_sh_q     <= dp_sh_d;
            blank_sh_q  <= blank_sh_d;
            blink_sh_q  <= blink_sh_d;
            bri_sh_q    <= bri_sh_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign disp.AN         = an_q;
    assign disp.Seg        = seg_q;
    assign disp.DP         = dp_q;
    assign disp.frame_tick = tick_q;

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Self-checking bench for sev_seg_scanner: directed scenarios plus random input churn,
// compared every cycle against a cycle-count based reference model.
module tb_sev_seg_scanner;

    localparam int N   = 4;
    localparam int R   = 8;
    localparam int P   = 2;
    localparam int BF  = 2;
    localparam int FR  = N * R;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk;
    logic resetn;

    sev_seg_scanner_if #(.N_DIGITS(N), .PWM_BITS(P)) bus ();

    sev_seg_scanner #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (R),
        .PWM_BITS     (P),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .disp   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: n = cycles since reset release, plus the inputs captured at each frame start.
    int          n = 0;
    logic [15:0] sh_digits = '0;
    logic [3:0]  sh_dp     = '0;
    logic [3:0]  sh_blank  = '0;
    logic [3:0]  sh_blink  = '0;
    logic [1:0]  sh_bri    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Predicts the outputs produced by the current cycle, advances one clock, then compares.
    task automatic step();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic       exp_tick;
        int         slot;
        int         phase;
        bit         lit;
        if (!resetn) begin
            exp_an    = 4'hF;
            exp_seg   = 7'h7F;
            exp_dp    = 1'b1;
            exp_tick  = 1'b0;
            n         = 0;
            sh_digits = '0;
            sh_dp     = '0;
            sh_blank  = '0;
            sh_blink  = '0;
            sh_bri    = '0;
        end else begin
            slot     = (n / R) % N;
            phase    = (n / FR / BF) % 2;
            lit      = (n % R != 0) && ((n % (1 << P)) <= int'(sh_bri))
                       && !sh_blank[slot] && !(sh_blink[slot] && phase == 1);
            exp_an   = lit ? ~(4'b0001 << slot) : 4'hF;
            exp_seg  = GLYPH[sh_digits[slot*4 +: 4]];
            exp_dp   = ~sh_dp[slot];
            exp_tick = (n % FR) == FR - 1;
            if (n % FR == 0) begin
                sh_digits = bus.digits;
                sh_dp     = bus.dp;
                sh_blank  = bus.blank;
                sh_blink  = bus.blink;
                sh_bri    = bus.brightness;
            end
            n++;
        end
        @(posedge clk);
        #1;
        check("AN", 32'(bus.AN), 32'(exp_an));
        check("Seg", 32'(bus.Seg), 32'(exp_seg));
        check("DP", 32'(bus.DP), 32'(exp_dp));
        check("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
        check("an_onehot", 32'($countones(~bus.AN) <= 1), 32'd1);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Bounded wait: step until the model is inside the requested slot.
    task automatic run_to_slot(input int target, input string tag);
        int guard;
        guard = 0;
        while (((n / R) % N) != target && guard < 2 * FR) begin
            step();
            guard++;
        end
        check({tag, "_reached_slot"}, 32'(((n / R) % N) == target), 32'd1);
    endtask

    initial begin
        resetn         = 1'b0;
        bus.digits     = 16'h3210;
        bus.dp         = '0;
        bus.blank      = '0;
        bus.blink      = '0;
        bus.brightness = 2'd3;

        // Reset and release latency.
        run(3);
        check("reset_AN", 32'(bus.AN), 32'hF);
        check("reset_Seg", 32'(bus.Seg), 32'h7F);
        resetn = 1'b1;
        step();
        check("release_guard_AN", 32'(bus.AN), 32'hF);
        step();
        check("release_first_lit", 32'(bus.AN), 32'b1110);

        // Plain scan over two frames.
        run(2 * FR);

        // PWM dimming.
        bus.brightness = 2'd0;
        run(2 * FR);
        bus.brightness = 2'd2;
        run(2 * FR);
        bus.brightness = 2'd3;

        // Blink, blank and decimal point.
        bus.blink = 4'b0100;
        run(5 * FR);
        bus.blink = 4'b0000;
        bus.blank = 4'b0001;
        bus.dp    = 4'b1000;
        run(2 * FR);
        bus.blank = 4'b0000;
        bus.dp    = 4'b0000;
        run(FR);

        // Mid-frame change only shows from the next frame.
        run_to_slot(2, "shadow");
        bus.digits[7:4] = 4'hA;
        run(2 * FR);

        // Reset mid-scan in slot 2.
        run_to_slot(2, "midreset");
        run(3);
        resetn = 1'b0;
        step();
        check("midreset_AN", 32'(bus.AN), 32'hF);
        check("midreset_Seg", 32'(bus.Seg), 32'h7F);
        resetn = 1'b1;
        step();
        step();
        check("midreset_first_lit", 32'(bus.AN), 32'b1110);
        run(FR);

        // Random churn of all inputs, with occasional short resets.
        for (int i = 0; i < 40 * FR; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(4))
                    0: bus.digits     = 16'($urandom);
                    1: bus.dp         = 4'($urandom);
                    2: bus.blank      = 4'($urandom);
                    3: bus.blink      = 4'($urandom);
                    default: bus.brightness = 2'($urandom);
                endcase
            end
            resetn = ($urandom_range(399) != 0);
            step();
        end
        resetn = 1'b1;
        run(FR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
